// File: rtl/mul_div_if.sv
// Handshake and operand bundle between the execute stage and the
// iterative multiply/divide unit.
interface mul_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  flush;
  logic [2:0]            Funct3;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] Result;

  modport master (
    output start, flush, Funct3, SrcA, SrcB,
    input  busy, done, Result
  );

  modport slave (
    input  start, flush, Funct3, SrcA, SrcB,
    output busy, done, Result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign fix-up at
// the end. Divide-by-zero and signed overflow bypass the iteration.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | one multiplier/quotient bit per cycle, DATA_WIDTH cycles
// FIX   | sign correction, Result written, done pulsed next cycle
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic    clk,
  input logic    reset,
  mul_div_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [2:0]       f3;
  logic             sa, sb;
  logic             special;
  logic [W-1:0]     spec_val;
  logic [W-1:0]     opnd;
  logic [2*W-1:0]   acc;
  logic             busy_r, done_r;
  logic [W-1:0]     result_r;

  logic             sgn_a, sgn_b, sa_in, sb_in;
  logic [W-1:0]     mag_a_in, mag_b_in;
  logic             div_zero, div_ovf, special_in, accept;
  logic [W-1:0]     spec_val_in;
  logic [W:0]       mul_sum;
  logic [W:0]       div_shift;
  logic             div_ge;
  logic [W-1:0]     div_diff, rem_next;
  logic [2*W-1:0]   prod;
  logic [W-1:0]     quo, rmd, fix_val;

  // Decode the incoming request: operand signs, magnitudes and special cases.
  always_comb begin
    sgn_a = !((bus.Funct3 == 3'b011) || (bus.Funct3 == 3'b101) || (bus.Funct3 == 3'b111));
    sgn_b = (bus.Funct3 == 3'b000) || (bus.Funct3 == 3'b001) ||
            (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    sa_in = sgn_a & bus.SrcA[W-1];
    sb_in = sgn_b & bus.SrcB[W-1];
    mag_a_in = sa_in ? (~bus.SrcA + 1'b1) : bus.SrcA;
    mag_b_in = sb_in ? (~bus.SrcB + 1'b1) : bus.SrcB;
    div_zero = bus.Funct3[2] && (bus.SrcB == '0);
    div_ovf  = bus.Funct3[2] && !bus.Funct3[0] &&
               (bus.SrcA == {1'b1, {(W-1){1'b0}}}) && (bus.SrcB == '1);
    special_in = div_zero || div_ovf;
    if (div_zero)
      spec_val_in = bus.Funct3[1] ? bus.SrcA : '1;
    else
      spec_val_in = bus.Funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    accept = (state == IDLE) && bus.start && !bus.flush;
  end

  // One iteration step for each algorithm, plus the final sign-corrected value.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    // When div_ge holds the true difference is below opnd, so W bits suffice.
    div_diff  = div_shift[W-1:0] - opnd;
    rem_next  = div_ge ? div_diff : div_shift[W-1:0];
    prod      = (sa ^ sb) ? (~acc + 1'b1) : acc;
    quo       = acc[W-1:0];
    rmd       = acc[2*W-1:W];
    fix_val   = '0;
    case (f3)
      3'b000:  fix_val = prod[W-1:0];
      3'b001,
      3'b010,
      3'b011:  fix_val = prod[2*W-1:W];
      3'b100:  fix_val = (sa ^ sb) ? (~quo + 1'b1) : quo;
      3'b101:  fix_val = quo;
      3'b110:  fix_val = sa ? (~rmd + 1'b1) : rmd;
      default: fix_val = rmd;
    endcase
    if (special) fix_val = spec_val;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = special_in ? FIX : CALC;
      CALC:    if (cnt == CW'(W - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.flush) state_n = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Operand latch, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      f3       <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      special  <= 1'b0;
      spec_val <= '0;
      opnd     <= '0;
      acc      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      busy_r <= (state_n != IDLE);
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            f3       <= bus.Funct3;
            sa       <= sa_in;
            sb       <= sb_in;
            special  <= special_in;
            spec_val <= spec_val_in;
            cnt      <= '0;
            opnd     <= bus.Funct3[2] ? mag_b_in : mag_a_in;
            acc      <= {{W{1'b0}}, (bus.Funct3[2] ? mag_a_in : mag_b_in)};
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (f3[2]) acc <= {rem_next, acc[W-2:0], div_ge};
          else       acc <= {mul_sum, acc[W-1:1]};
        end
        FIX: begin
          if (!bus.flush) begin
            result_r <= fix_val;
            done_r   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.Result = result_r;
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative integer multiply/divide unit for the RV32M extension. It sits in the execute stage beside the ALU and consumes the same decoded instruction fields that drive ALU operation selection. The decoder routes an instruction here when ALUOp == 2'b10 and Funct7 == 7'b0000001. The unit holds the pipeline through `busy` until a registered 32-bit result is ready.

## Interface
- `DATA_WIDTH`, 32: operand and result width; iteration count equals `DATA_WIDTH`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset: one clock, synchronous, active-high.
- `start`  in  1  request strobe; accepted only when `busy` == 0.
- `flush`  in  1  pipeline flush; aborts any operation in progress.
- `Funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA`  in  DATA_WIDTH  rs1 operand (multiplicand / dividend).
- `SrcB`  in  DATA_WIDTH  rs2 operand (multiplier / divisor).
- `busy`  out  1  operation in progress; the hazard unit stalls IF/ID/EX while high.
- `done`  out  1  one-cycle pulse; `Result` is valid from this cycle on.
- `Result`  out  DATA_WIDTH  registered result; holds its value until the next completion.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, with `start` high and `flush` low:
  - Latch `Funct3`, the operand magnitudes and the operand signs.
  - Clear the iteration counter.
  - Go to CALC, or go straight to FIX on a special case.
- Sign rules:
  - SrcA is signed for MUL, MULH, MULHSU, DIV and REM.
  - SrcB is signed for MUL, MULH, DIV and REM.
  - Unsigned ops use raw values with sign bits forced to 0.
- Multiply: shift-add on magnitudes, one multiplier bit per cycle, into a 2*DATA_WIDTH accumulator.
  - Product sign is sA ^ sB. FIX negates the full 64-bit product when that sign is 1.
  - MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring division on magnitudes, one quotient bit per cycle.
  - DIV negates the quotient when sA ^ sB.
  - REM negates the remainder when sA (remainder takes the dividend's sign).
- Special cases are detected in IDLE at `start` and skip CALC:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give SrcA.
  - DIV with SrcA == 0x80000000 and SrcB == 0xFFFFFFFF gives 0x80000000; the matching REM gives 0.
- CALC runs exactly DATA_WIDTH cycles; the counter goes 0..DATA_WIDTH-1, and at DATA_WIDTH-1 the next state is FIX.
- FIX applies sign correction, writes `Result`, pulses `done` on the next cycle, and returns to IDLE.
- `flush` in any state: next state IDLE, no `done`, `Result` unchanged.
- `start` while `busy` is ignored; latched operands are unaffected.
- `start` and `flush` in the same cycle: `flush` wins and the request is dropped.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `Result` 0, counter 0, accumulators 0.
- `start` accepted in cycle T:
  - `busy` is high T+1..T+DATA_WIDTH+1 (32 CALC cycles plus 1 FIX).
  - `done` and the new `Result` appear at T+DATA_WIDTH+2 (T+34), when `busy` is already 0.
- Special case accepted in cycle T: `busy` high at T+1 only; `done` at T+2.
- Back-to-back: a new `start` may be accepted in the same cycle `done` is high.
- `busy` is a registered output; `done` is high for exactly one cycle per completed operation.
- `reset` mid-operation: next cycle all outputs equal their reset values and no `done` is issued.
- Arithmetic wraps modulo 2^DATA_WIDTH; no overflow flag is produced.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3), start at T → `busy` T+1..T+33, `done` at T+34, `Result` 0xFFFFFFEB.
- High products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF.
  - DIVU 100 / 7 → 0x0000000E; REMU 100 / 7 → 0x00000002.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF with `done` at T+2; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Flush and ignored start: DIVU started at T, `flush` at T+10 → `busy` 0 at T+11, no `done`, `Result` keeps its prior value. A `start` pulse at T+5 of an uninterrupted operation is ignored and the original result is returned.
- Reset: assert `reset` at T+20 of a MUL → `busy`, `done` and `Result` read 0 at T+21. A following MUL 3×4 completes with 0x0000000C at 34 cycles after its start.
